// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the sequential ALU blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 32;
    localparam int DIGIT_DEF = 4;
    localparam int NDIG_DEF  = WIDTH_DEF / DIGIT_DEF;

    // Digit counter must be able to hold the digit count itself.
    function automatic int cnt_width(input int ndig);
        return $clog2(ndig + 1);
    endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT-bit adder with carry-in and carry-out.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             c_o
);

    logic [DIGIT:0] total;

    assign total = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT{1'b0}}, c_i};
    assign sum_o = total[DIGIT-1:0];
    assign c_o   = total[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit add/subtract with carry/borrow out and signed overflow.
// Latency: WIDTH/DIGIT+1 cycles from accepted start to the done pulse.
// Backpressure: none; start is ignored while busy, accepted in IDLE or DONE.
module serial_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   S,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_addsub: DIGIT must divide WIDTH");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]   s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0]       dig_sum;
    logic                   dig_co;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_next;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a_i   (a_q[DIGIT-1:0]),
        .b_i   (b_q[DIGIT-1:0]),
        .c_i   (carry_q),
        .sum_o (dig_sum),
        .c_o   (dig_co)
    );

    // New digit enters at the top; after NDIG digits the LSB digit sits at bit 0.
    assign acc_cat  = {dig_sum, acc_q};
    assign acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];

    // Next-state and datapath: subtract runs as A + ~B + ~cin, borrow = ~carry.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub ? ~cin : cin;
                    sub_d   = sub;
                    cnt_d   = '0;
                    amsb_d  = A[WIDTH-1];
                    bmsb_d  = sub ? ~B[WIDTH-1] : B[WIDTH-1];
                end
            end
            RUN: begin
                acc_d   = acc_next;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    state_d = DONE;
                    s_d     = {sub_q ? ~dig_co : dig_co, acc_next};
                    ovf_d   = (amsb_q == bmsb_q) && (acc_next[WIDTH-1] != amsb_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign S    = s_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub with a plain-arithmetic reference model.
// Latency: expects done 9 cycles after an accepted start (32-bit, 4-bit digits).
// Backpressure: exercises ignored mid-run start and start held during done.
module tb_serial_addsub;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [31:0] A;
    logic [31:0] B;
    logic        cin;
    logic        busy;
    logic        done;
    logic [32:0] S;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;

    serial_addsub #(.WIDTH(32), .DIGIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy && done) overlap_cnt++;
    end

    // Reference: {ovf, S} straight from the arithmetic definition.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic sb);
        logic [32:0] s;
        logic [31:0] be;
        logic        o;
        if (sb) begin
            s  = {1'b0, a} - {1'b0, b} - {32'd0, ci};
            be = ~b;
        end else begin
            s  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
            be = b;
        end
        o = (a[31] == be[31]) && (s[31] != a[31]);
        return {o, s};
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb);
        A = a; B = b; cin = ci; sub = sb; start = 1'b1;
    endtask

    // Called at the negedge where start is asserted; returns at the done cycle.
    task automatic wait_done(output int lat, output logic [32:0] s, output logic o,
                             output int busy_gaps);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_gaps = 0;
        while (!done && lat < 40) begin
            if (!busy) busy_gaps++;
            @(negedge clk);
            lat++;
        end
        s = S;
        o = ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0; cin = 1'b0;
        #1;
        total++;
        if ({busy, done, S, ovf} !== 36'd0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b S=%h ovf=%b, want all 0", busy, done, S, ovf);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] ta [7] = '{32'hFFFFFFFF, 32'h5, 32'h7, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h0};
        logic [31:0] tb [7] = '{32'h1, 32'h7, 32'h5, 32'h1, 32'h1, 32'h80000000, 32'h0};
        logic        tc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [32:0] es [7] = '{33'h1_00000000, 33'h1_FFFFFFFE, 33'h0_00000002, 33'h0_80000000,
                                33'h0_7FFFFFFF, 33'h1_00000001, 33'h1_FFFFFFFF};
        logic        eo [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int lat, gaps;
        logic [32:0] s;
        logic o;
        for (int i = 0; i < 7; i++) begin
            launch(ta[i], tb[i], tc[i], ts[i]);
            wait_done(lat, s, o, gaps);
            total++;
            if (lat !== 9) begin
                bad++;
                $display("FAIL dir_latency[%0d]: got %0d, want 9", i, lat);
            end
            total++;
            if (s !== es[i] || o !== eo[i]) begin
                bad++;
                $display("FAIL dir_result[%0d]: S=%h ovf=%b, want S=%h ovf=%b", i, s, o, es[i], eo[i]);
            end
            total++;
            if (gaps !== 0) begin
                bad++;
                $display("FAIL dir_busy[%0d]: busy low %0d cycles during run, want 0", i, gaps);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || S !== es[i]) begin
                bad++;
                $display("FAIL dir_after_done[%0d]: done=%b S=%h, want done=0 S=%h", i, done, S, es[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, gaps;
        logic [32:0] s;
        logic o;
        logic [33:0] exp;
        logic [31:0] a, b;
        logic ci, sb;
        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            b  = (i % 4 == 0) ? a : $urandom;
            ci = $urandom_range(0, 1);
            sb = $urandom_range(0, 1);
            exp = model(a, b, ci, sb);
            launch(a, b, ci, sb);
            wait_done(lat, s, o, gaps);
            total++;
            if (lat !== 9 || s !== exp[32:0] || o !== exp[33]) begin
                bad++;
                $display("FAIL rand[%0d]: a=%h b=%h cin=%b sub=%b lat=%0d S=%h ovf=%b, want lat=9 S=%h ovf=%b",
                         i, a, b, ci, sb, lat, s, o, exp[32:0], exp[33]);
            end
            if (i % 3 == 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        logic [33:0] exp;
        int lat;
        exp = model(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b1);
        launch(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (2) begin @(negedge clk); lat++; end
        launch(32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b0);
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        total++;
        if (lat !== 9 || S !== exp[32:0] || ovf !== exp[33]) begin
            bad++;
            $display("FAIL ignore_start: lat=%0d S=%h ovf=%b, want lat=9 S=%h ovf=%b", lat, S, ovf, exp[32:0], exp[33]);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] e1, e2;
        int lat, gaps;
        logic [32:0] s;
        logic o;
        e1 = model(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0);
        e2 = model(32'h00000010, 32'h00000020, 1'b1, 1'b1);
        launch(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0);
        wait_done(lat, s, o, gaps);
        total++;
        if (s !== e1[32:0] || o !== e1[33]) begin
            bad++;
            $display("FAIL b2b_first: S=%h ovf=%b, want S=%h ovf=%b", s, o, e1[32:0], e1[33]);
        end
        launch(32'h00000010, 32'h00000020, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_busy_next: busy=%b done=%b, want 1 0", busy, done);
        end
        lat = 1;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        total++;
        if (lat !== 9 || S !== e2[32:0] || ovf !== e2[33]) begin
            bad++;
            $display("FAIL b2b_second: lat=%0d S=%h ovf=%b, want lat=9 S=%h ovf=%b", lat, S, ovf, e2[32:0], e2[33]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat, gaps, snap;
        logic [32:0] s;
        logic o;
        logic [33:0] exp;
        launch(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, S, ovf} !== 36'd0) begin
            bad++;
            $display("FAIL reset_mid_run: busy=%b done=%b S=%h ovf=%b, want all 0", busy, done, S, ovf);
        end
        snap = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        total++;
        if (done_cnt !== snap) begin
            bad++;
            $display("FAIL reset_no_done: %0d done pulses after reset, want 0", done_cnt - snap);
        end
        exp = model(32'h80000000, 32'h00000001, 1'b0, 1'b1);
        launch(32'h80000000, 32'h00000001, 1'b0, 1'b1);
        wait_done(lat, s, o, gaps);
        total++;
        if (lat !== 9 || s !== exp[32:0] || o !== exp[33]) begin
            bad++;
            $display("FAIL reset_recover: lat=%0d S=%h ovf=%b, want lat=9 S=%h ovf=%b", lat, s, o, exp[32:0], exp[33]);
        end
        @(negedge clk);
    endtask

    task automatic test_pulse_count(input int ops);
        total++;
        if (done_cnt !== ops) begin
            bad++;
            $display("FAIL done_pulses: got %0d cycles with done, want %0d", done_cnt, ops);
        end
        total++;
        if (overlap_cnt !== 0) begin
            bad++;
            $display("FAIL busy_done_overlap: %0d cycles, want 0", overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_pulse_count(7 + 40 + 1 + 2 + 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
